// File: rtl/shot_controller_if.sv
// -----------------------------------------------------------------------------
// shot_controller_if
// Shot/result link between the shot sequencer and the board/ship logic.
//
// Handshake: the master raises shot_valid with shot_cell stable and holds both
// until a cycle in which shot_valid and shot_ready are high together; that cycle
// is the transfer. The board answers later with a one-cycle result_valid strobe.
// result_hit and all_sunk are meaningful only while result_valid is high.
//
// Signals:
//   shot_valid   master -> slave  shot request
//   shot_cell    master -> slave  target cell index (row*GRID_N + col)
//   shot_ready   slave  -> master board accepts the shot
//   result_valid slave  -> master result strobe
//   result_hit   slave  -> master result is a hit
//   all_sunk     slave  -> master every opponent ship is sunk
// -----------------------------------------------------------------------------
interface shot_controller_if;
  logic       shot_valid;
  logic [6:0] shot_cell;
  logic       shot_ready;
  logic       result_valid;
  logic       result_hit;
  logic       all_sunk;

  modport master (
    output shot_valid, shot_cell,
    input  shot_ready, result_valid, result_hit, all_sunk
  );

  modport slave (
    input  shot_valid, shot_cell,
    output shot_ready, result_valid, result_hit, all_sunk
  );
endinterface

// File: rtl/shot_controller.sv
// -----------------------------------------------------------------------------
// shot_controller
// Turn and shot sequencer for a GRID_N x GRID_N battleships grid. Accepts the
// cursor position on a select pulse during the player's turn, rejects
// out-of-range or already-fired cells, sends the shot to the board over the
// bus interface, waits for the result (with timeout), keeps shot history and
// score, and hands the turn to the opponent after a miss.
//
// Optional feature: define SHOT_LIMIT_EN to end the game as a loss once
// MAX_SHOTS shots have resolved without all ships sunk.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   game_start            start pulse (honoured in IDLE and GAME_OVER only)
//   cursor_row/col        cursor position, valid values 0..GRID_N-1
//   btn_select            fire request (honoured in PLAYER_AIM only)
//   opp_done              opponent finished its turn
//   bus                   shot/result link (master side)
//   player_turn           high in PLAYER_AIM; cursor movement enable
//   dup_shot              pulse: rejected selection
//   timeout_err           pulse: no result within RESULT_TIMEOUT cycles
//   shot_count/hit_count  resolved shots / hits this game, saturating
//   game_over/player_won  end of game and its outcome
//   dbg_state             current FSM state encoding
// -----------------------------------------------------------------------------
module shot_controller #(
  parameter int GRID_N         = 10,
  parameter int RESULT_TIMEOUT = 64,
  parameter int MAX_SHOTS      = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_start,
  input  logic [3:0] cursor_row,
  input  logic [3:0] cursor_col,
  input  logic       btn_select,
  input  logic       opp_done,
  shot_controller_if.master bus,
  output logic       player_turn,
  output logic       dup_shot,
  output logic       timeout_err,
  output logic [6:0] shot_count,
  output logic [6:0] hit_count,
  output logic       game_over,
  output logic       player_won,
  output logic [2:0] dbg_state
);

  localparam int         CELLS    = GRID_N * GRID_N;
  localparam logic [6:0] GRID_N7  = 7'(GRID_N);
  localparam logic [6:0] CNT_SAT  = 7'(CELLS);
  localparam logic [6:0] SHOT_MAX = 7'(MAX_SHOTS);
  localparam int         TW       = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESULT_TIMEOUT - 1);

`ifdef SHOT_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAYER_AIM  = 3'd1,
    FIRE_REQ    = 3'd2,
    WAIT_RESULT = 3'd3,
    OPP_TURN    = 3'd4,
    GAME_OVER   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] history_q;
  logic [6:0]       shot_cell_q;
  logic [6:0]       shot_cnt_q, hit_cnt_q;
  logic [TW-1:0]    tmo_cnt_q;
  logic             dup_q, tmo_err_q, won_q;

  // Events decoded by the next-state logic and consumed by the datapath.
  logic       start_evt, sel_ok, sel_bad, res_evt, tmo_evt;
  logic [6:0] sel_idx, shot_nxt, hit_nxt;
  logic       limit_hit;

  assign sel_idx  = {3'b000, cursor_row} * GRID_N7 + {3'b000, cursor_col};
  assign shot_nxt = (shot_cnt_q == CNT_SAT) ? shot_cnt_q : shot_cnt_q + 7'd1;
  assign hit_nxt  = (hit_cnt_q == CNT_SAT || !bus.result_hit) ? hit_cnt_q
                                                              : hit_cnt_q + 7'd1;
  // Only matters in the limit build; constant-false otherwise.
  assign limit_hit = LIMIT_ON && (shot_nxt == SHOT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and event decode
  always_comb begin
    state_d   = state_q;
    start_evt = 1'b0;
    sel_ok    = 1'b0;
    sel_bad   = 1'b0;
    res_evt   = 1'b0;
    tmo_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (game_start) begin
          start_evt = 1'b1;
          state_d   = PLAYER_AIM;
        end
      end
      PLAYER_AIM: begin
        if (btn_select) begin
          // Range is checked first so the history lookup only matters in range.
          if (cursor_row >= 4'(GRID_N) || cursor_col >= 4'(GRID_N) ||
              history_q[sel_idx]) begin
            sel_bad = 1'b1;
          end else begin
            sel_ok  = 1'b1;
            state_d = FIRE_REQ;
          end
        end
      end
      FIRE_REQ: begin
        if (bus.shot_ready) state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        // A result arriving on the expiry cycle takes precedence.
        if (bus.result_valid) begin
          res_evt = 1'b1;
          if (bus.all_sunk || limit_hit) state_d = GAME_OVER;
          else if (bus.result_hit)       state_d = PLAYER_AIM;
          else                           state_d = OPP_TURN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_evt = 1'b1;
          state_d = PLAYER_AIM;
        end
      end
      OPP_TURN: begin
        if (opp_done) state_d = PLAYER_AIM;
      end
      GAME_OVER: begin
        if (game_start) begin
          start_evt = 1'b1;
          state_d   = PLAYER_AIM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: history, score, target latch, timeout counter, pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      history_q   <= '0;
      shot_cell_q <= '0;
      shot_cnt_q  <= '0;
      hit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      dup_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
      won_q       <= 1'b0;
    end else begin
      dup_q     <= sel_bad;
      tmo_err_q <= tmo_evt;
      if (start_evt) begin
        history_q  <= '0;
        shot_cnt_q <= '0;
        hit_cnt_q  <= '0;
        won_q      <= 1'b0;
      end
      if (sel_ok) shot_cell_q <= sel_idx;
      // Held at zero while the request is pending, so it starts at zero on
      // the first WAIT_RESULT cycle after the transfer.
      if (state_q == FIRE_REQ)         tmo_cnt_q <= '0;
      else if (state_q == WAIT_RESULT) tmo_cnt_q <= tmo_cnt_q + TW'(1);
      if (res_evt) begin
        history_q[shot_cell_q] <= 1'b1;
        shot_cnt_q             <= shot_nxt;
        hit_cnt_q              <= hit_nxt;
        won_q                  <= bus.all_sunk;
      end
    end
  end

  // Outputs
  always_comb begin
    player_turn    = (state_q == PLAYER_AIM);
    bus.shot_valid = (state_q == FIRE_REQ);
    bus.shot_cell  = shot_cell_q;
    game_over      = (state_q == GAME_OVER);
    player_won     = (state_q == GAME_OVER) && won_q;
    dup_shot       = dup_q;
    timeout_err    = tmo_err_q;
    shot_count     = shot_cnt_q;
    hit_count      = hit_cnt_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_shot_controller.sv
module tb_shot_controller;

`ifdef SHOT_LIMIT_EN
  localparam int MAXS = 3;
`else
  localparam int MAXS = 100;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_AIM = 3'd1, S_FIRE = 3'd2,
                         S_WAIT = 3'd3, S_OPP = 3'd4, S_OVER = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       game_start = 1'b0;
  logic [3:0] cursor_row = '0;
  logic [3:0] cursor_col = '0;
  logic       btn_select = 1'b0;
  logic       opp_done = 1'b0;
  logic       player_turn, dup_shot, timeout_err, game_over, player_won;
  logic [6:0] shot_count, hit_count;
  logic [2:0] dbg_state;

  int n_pass = 0;
  int n_total = 0;

  shot_controller_if bus ();

  shot_controller #(.GRID_N(10), .RESULT_TIMEOUT(64), .MAX_SHOTS(MAXS)) dut (
    .clk(clk), .reset(reset), .game_start(game_start),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .btn_select(btn_select), .opp_done(opp_done), .bus(bus),
    .player_turn(player_turn), .dup_shot(dup_shot), .timeout_err(timeout_err),
    .shot_count(shot_count), .hit_count(hit_count), .game_over(game_over),
    .player_won(player_won), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Driver tasks
  task automatic pulse_start();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
  endtask

  task automatic select(input logic [3:0] r, input logic [3:0] c);
    cursor_row = r;
    cursor_col = c;
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
  endtask

  task automatic handshake();
    bus.shot_ready = 1'b1;
    tick();
    bus.shot_ready = 1'b0;
  endtask

  task automatic result(input logic hit, input logic sunk);
    bus.result_valid = 1'b1;
    bus.result_hit   = hit;
    bus.all_sunk     = sunk;
    tick();
    bus.result_valid = 1'b0;
    bus.result_hit   = 1'b0;
    bus.all_sunk     = 1'b0;
  endtask

  task automatic fire(input logic [3:0] r, input logic [3:0] c,
                      input logic hit, input logic sunk);
    select(r, c);
    handshake();
    result(hit, sunk);
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    n_total++; if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); else n_pass++;
    n_total++; if ({player_turn, bus.shot_valid, dup_shot, timeout_err, game_over, player_won} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {player_turn, bus.shot_valid, dup_shot, timeout_err, game_over, player_won}); else n_pass++;
    n_total++; if ({bus.shot_cell, shot_count, hit_count} !== 21'd0)
      $display("FAIL reset_counts: got cell %0d shots %0d hits %0d want 0 0 0", bus.shot_cell, shot_count, hit_count); else n_pass++;
    // btn_select is ignored outside PLAYER_AIM.
    select(4'd1, 4'd1);
    n_total++; if (dbg_state !== S_IDLE) $display("FAIL idle_ignores_select: got %0d want %0d", dbg_state, S_IDLE); else n_pass++;
  endtask

  task automatic test_first_shot();
    pulse_start();
    n_total++; if (player_turn !== 1'b1) $display("FAIL start_player_turn: got %b want 1", player_turn); else n_pass++;
    select(4'd2, 4'd3);
    n_total++; if (bus.shot_valid !== 1'b1) $display("FAIL first_valid_latency: got %b want 1", bus.shot_valid); else n_pass++;
    n_total++; if (bus.shot_cell !== 7'd23) $display("FAIL first_cell: got %0d want 23", bus.shot_cell); else n_pass++;
    n_total++; if (player_turn !== 1'b0) $display("FAIL fire_player_turn: got %b want 0", player_turn); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if (bus.shot_valid !== 1'b1 || bus.shot_cell !== 7'd23)
        $display("FAIL hold_stable_%0d: got valid %b cell %0d want 1 23", i, bus.shot_valid, bus.shot_cell); else n_pass++;
    end
    handshake();
    n_total++; if (dbg_state !== S_WAIT || bus.shot_valid !== 1'b0)
      $display("FAIL after_handshake: got state %0d valid %b want %0d 0", dbg_state, bus.shot_valid, S_WAIT); else n_pass++;
  endtask

  task automatic test_miss_path();
    result(1'b0, 1'b0);
    n_total++; if (shot_count !== 7'd1 || hit_count !== 7'd0)
      $display("FAIL miss_counts: got shots %0d hits %0d want 1 0", shot_count, hit_count); else n_pass++;
    n_total++; if (dbg_state !== S_OPP || player_turn !== 1'b0)
      $display("FAIL miss_state: got state %0d turn %b want %0d 0", dbg_state, player_turn, S_OPP); else n_pass++;
    select(4'd5, 4'd5);
    n_total++; if (dbg_state !== S_OPP || bus.shot_valid !== 1'b0)
      $display("FAIL opp_ignores_select: got state %0d valid %b want %0d 0", dbg_state, bus.shot_valid, S_OPP); else n_pass++;
    opp_done = 1'b1;
    tick();
    opp_done = 1'b0;
    n_total++; if (player_turn !== 1'b1) $display("FAIL opp_done_turn: got %b want 1", player_turn); else n_pass++;
  endtask

  task automatic test_duplicates();
    select(4'd2, 4'd3);
    n_total++; if (dup_shot !== 1'b1 || bus.shot_valid !== 1'b0 || player_turn !== 1'b1)
      $display("FAIL dup_repeat: got dup %b valid %b turn %b want 1 0 1", dup_shot, bus.shot_valid, player_turn); else n_pass++;
    tick();
    n_total++; if (dup_shot !== 1'b0) $display("FAIL dup_one_cycle: got %b want 0", dup_shot); else n_pass++;
    select(4'd10, 4'd0);
    n_total++; if (dup_shot !== 1'b1 || bus.shot_valid !== 1'b0)
      $display("FAIL dup_row_range: got dup %b valid %b want 1 0", dup_shot, bus.shot_valid); else n_pass++;
    select(4'd0, 4'd12);
    n_total++; if (dup_shot !== 1'b1 || bus.shot_valid !== 1'b0)
      $display("FAIL dup_col_range: got dup %b valid %b want 1 0", dup_shot, bus.shot_valid); else n_pass++;
    select(4'd9, 4'd9);
    n_total++; if (bus.shot_valid !== 1'b1 || bus.shot_cell !== 7'd99 || dup_shot !== 1'b0)
      $display("FAIL corner_cell: got valid %b cell %0d dup %b want 1 99 0", bus.shot_valid, bus.shot_cell, dup_shot); else n_pass++;
    handshake();
  endtask

  task automatic test_hit_and_win();
    result(1'b1, 1'b0);
    n_total++; if (dbg_state !== S_AIM || hit_count !== 7'd1 || shot_count !== 7'd2)
      $display("FAIL hit_again: got state %0d hits %0d shots %0d want %0d 1 2", dbg_state, hit_count, shot_count, S_AIM); else n_pass++;
    fire(4'd0, 4'd0, 1'b1, 1'b1);
    n_total++; if (game_over !== 1'b1 || player_won !== 1'b1)
      $display("FAIL win: got over %b won %b want 1 1", game_over, player_won); else n_pass++;
    n_total++; if (shot_count !== 7'd3 || hit_count !== 7'd2 || player_turn !== 1'b0)
      $display("FAIL win_counts: got shots %0d hits %0d turn %b want 3 2 0", shot_count, hit_count, player_turn); else n_pass++;
    select(4'd4, 4'd4);
    n_total++; if (game_over !== 1'b1 || bus.shot_valid !== 1'b0 || bus.shot_cell !== 7'd0)
      $display("FAIL over_holds: got over %b valid %b cell %0d want 1 0 0", game_over, bus.shot_valid, bus.shot_cell); else n_pass++;
  endtask

  task automatic test_restart();
    pulse_start();
    n_total++; if (shot_count !== 7'd0 || hit_count !== 7'd0 || game_over !== 1'b0 || player_turn !== 1'b1)
      $display("FAIL restart: got shots %0d hits %0d over %b turn %b want 0 0 0 1", shot_count, hit_count, game_over, player_turn); else n_pass++;
    select(4'd2, 4'd3);
    n_total++; if (bus.shot_valid !== 1'b1 || bus.shot_cell !== 7'd23 || dup_shot !== 1'b0)
      $display("FAIL restart_reselect: got valid %b cell %0d dup %b want 1 23 0", bus.shot_valid, bus.shot_cell, dup_shot); else n_pass++;
    // game_start is ignored outside IDLE and GAME_OVER.
    pulse_start();
    n_total++; if (dbg_state !== S_FIRE) $display("FAIL start_ignored: got %0d want %0d", dbg_state, S_FIRE); else n_pass++;
  endtask

  task automatic test_timeout();
    handshake();
    for (int i = 0; i < 63; i++) tick();
    n_total++; if (dbg_state !== S_WAIT || timeout_err !== 1'b0)
      $display("FAIL before_timeout: got state %0d err %b want %0d 0", dbg_state, timeout_err, S_WAIT); else n_pass++;
    tick();
    n_total++; if (timeout_err !== 1'b1 || player_turn !== 1'b1 || shot_count !== 7'd0)
      $display("FAIL timeout: got err %b turn %b shots %0d want 1 1 0", timeout_err, player_turn, shot_count); else n_pass++;
    tick();
    n_total++; if (timeout_err !== 1'b0) $display("FAIL timeout_one_cycle: got %b want 0", timeout_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    select(4'd2, 4'd3);
    n_total++; if (bus.shot_valid !== 1'b1 || dup_shot !== 1'b0)
      $display("FAIL refire_after_timeout: got valid %b dup %b want 1 0", bus.shot_valid, dup_shot); else n_pass++;
    handshake();
    do_reset();
    n_total++; if (dbg_state !== S_IDLE || {player_turn, bus.shot_valid, game_over, player_won} !== 4'b0 || bus.shot_cell !== 7'd0)
      $display("FAIL reset_in_wait: got state %0d flags %b cell %0d want %0d 0000 0", dbg_state,
               {player_turn, bus.shot_valid, game_over, player_won}, bus.shot_cell, S_IDLE); else n_pass++;
    pulse_start();
    select(4'd1, 4'd1);
    reset = 1'b1;
    bus.shot_ready = 1'b1;
    tick();
    reset = 1'b0;
    bus.shot_ready = 1'b0;
    n_total++; if (dbg_state !== S_IDLE || bus.shot_valid !== 1'b0)
      $display("FAIL reset_in_handshake: got state %0d valid %b want %0d 0", dbg_state, bus.shot_valid, S_IDLE); else n_pass++;
  endtask

`ifdef SHOT_LIMIT_EN
  task automatic test_shot_limit();
    do_reset();
    pulse_start();
    fire(4'd0, 4'd1, 1'b0, 1'b0);
    opp_done = 1'b1;
    tick();
    opp_done = 1'b0;
    fire(4'd0, 4'd2, 1'b1, 1'b0);
    n_total++; if (game_over !== 1'b0 || dbg_state !== S_AIM)
      $display("FAIL limit_early: got over %b state %0d want 0 %0d", game_over, dbg_state, S_AIM); else n_pass++;
    fire(4'd0, 4'd3, 1'b0, 1'b0);
    n_total++; if (game_over !== 1'b1 || player_won !== 1'b0 || shot_count !== 7'd3)
      $display("FAIL limit_loss: got over %b won %b shots %0d want 1 0 3", game_over, player_won, shot_count); else n_pass++;
  endtask
`endif

  initial begin
    bus.shot_ready   = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_hit   = 1'b0;
    bus.all_sunk     = 1'b0;
    test_reset();
    test_first_shot();
    test_miss_path();
    test_duplicates();
    test_hit_and_win();
    test_restart();
    test_timeout();
    test_reset_mid();
`ifdef SHOT_LIMIT_EN
    test_shot_limit();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Turn and shot sequencer for the 10×10 battleships grid.
- Takes the cursor position and a select pulse during the player's turn, and rejects invalid or repeated targets.
- Issues a shot to the board/ship logic over a valid/ready handshake and waits for the hit/miss result.
- Tracks shot history and score, then hands the turn to the opponent. It drives the player_turn enable that gates cursor movement.

Parameters:
- GRID_N, 10, grid dimension; cell index = row*GRID_N + col, range 0..99.
- RESULT_TIMEOUT, 64, cycles to wait in WAIT_RESULT before aborting the shot.
- MAX_SHOTS, 100, shot budget; used only when SHOT_LIMIT_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- game_start  in  1  one-cycle pulse that starts a game from IDLE or GAME_OVER
- cursor_row  in  4  cursor row, 0..9
- cursor_col  in  4  cursor column, 0..9
- btn_select  in  1  one-cycle, debounced fire request
- shot_ready  in  1  board accepts the shot
- result_valid  in  1  board result strobe
- result_hit  in  1  result is a hit; qualified by result_valid
- all_sunk  in  1  all opponent ships sunk; qualified by result_valid
- opp_done  in  1  pulse: opponent finished its turn
- player_turn  out  1  high only in PLAYER_AIM; drives the cursor enable
- shot_valid  out  1  shot request to the board
- shot_cell  out  7  latched target cell index
- dup_shot  out  1  one-cycle pulse: selected cell was already fired or is out of range
- timeout_err  out  1  one-cycle pulse: result did not arrive in time
- shot_count  out  7  shots resolved this game
- hit_count  out  7  hits this game
- game_over  out  1  high in GAME_OVER
- player_won  out  1  valid while game_over is high

Behaviour:
- All state is updated on the rising edge of clk only. reset is synchronous, active-high and takes priority over all other inputs.
- Reset values:
  - State = IDLE.
  - All outputs = 0; shot_cell = 0.
  - The 100-bit shot history is cleared.
  - Counters = 0.
- FSM states: IDLE, PLAYER_AIM, FIRE_REQ, WAIT_RESULT, OPP_TURN, GAME_OVER.
- IDLE:
  - game_start → clear history and counters, go to PLAYER_AIM.
- PLAYER_AIM (player_turn = 1). On btn_select, compute idx = cursor_row*10 + cursor_col with 7-bit arithmetic:
  - If row > 9, col > 9, or history[idx] is set → pulse dup_shot the next cycle and stay in PLAYER_AIM.
  - Otherwise latch shot_cell = idx and go to FIRE_REQ.
- FIRE_REQ:
  - shot_valid = 1; shot_cell is held stable.
  - Transfer completes in a cycle where shot_valid and shot_ready are both high. Then go to WAIT_RESULT and clear the timeout counter.
  - shot_valid is never dropped before shot_ready.
- WAIT_RESULT, on result_valid:
  - Set history[shot_cell]; shot_count += 1; hit_count += result_hit.
  - If all_sunk → GAME_OVER with player_won = 1.
  - Else if result_hit → PLAYER_AIM (a hit earns another shot).
  - Else → OPP_TURN.
- WAIT_RESULT timeout: if the counter reaches RESULT_TIMEOUT-1 with no result_valid → pulse timeout_err and return to PLAYER_AIM. History and counters are unchanged, so the same cell may be re-fired.
- Simultaneous result_valid and timeout expiry: the result wins.
- OPP_TURN:
  - opp_done → PLAYER_AIM.
  - btn_select is ignored here.
- GAME_OVER:
  - Outputs are held.
  - game_start → clear history and counters, go to PLAYER_AIM.
- btn_select is ignored in every state except PLAYER_AIM.
- game_start is ignored in every state except IDLE and GAME_OVER.
- Latency: a valid select in cycle N drives shot_valid high in cycle N+1.
- Counters saturate at 100.
- Reset in any state, including mid-handshake, forces IDLE and drops shot_valid the next cycle.

Optional Feature:
- Macro: SHOT_LIMIT_EN.
- Defined:
  - After a result that leaves shot_count == MAX_SHOTS with all_sunk = 0, go to GAME_OVER with player_won = 0, regardless of result_hit.
  - all_sunk on the final shot still gives player_won = 1.
- Undefined:
  - No shot limit; MAX_SHOTS is unused.
  - player_won is 1 whenever game_over is high.

Test Plan:
- Reset → game_start → select at row 2, col 3:
  - shot_valid rises 1 cycle later with shot_cell = 23.
  - shot_ready held low for 5 cycles → shot_valid and shot_cell held stable throughout.
- Miss path: result_valid = 1, result_hit = 0 →
  - shot_count = 1, hit_count = 0, state OPP_TURN, player_turn = 0.
  - btn_select in OPP_TURN is ignored.
  - opp_done → player_turn = 1.
- Duplicates: re-select cell 23 → dup_shot pulses one cycle, no shot_valid. Select row 9, col 9 → shot_cell = 99.
- Hit and win:
  - Hit → returns directly to PLAYER_AIM, hit_count = 1.
  - Next result with all_sunk = 1 → game_over = 1, player_won = 1.
  - game_start → counters = 0 and cell 23 is selectable again.
- Timeout: no result for 64 cycles → timeout_err pulse, back to PLAYER_AIM, shot_count unchanged. Assert reset in WAIT_RESULT → IDLE, all outputs 0 next cycle.
- SHOT_LIMIT_EN, MAX_SHOTS = 3: three shots as miss, hit, miss with no all_sunk → game_over = 1, player_won = 0 after the third result.
